dma_responder: RTL and testbench



---
 rtl/dma_responder_pkg.sv | 26 ++
 rtl/dma_responder_mem.sv | 28 ++
 rtl/dma_responder.sv | 204 ++++++++++++++++++++
 tb/tb_dma_responder.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_responder_pkg.sv
// Shared definitions for dma_responder: FSM state encodings, config register
// byte offsets, CTRL bit positions and a saturating counter helper.
package dma_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Byte offsets of the config registers inside the peripheral window
  localparam logic [7:0] CTRL_OFF   = 8'h00;
  localparam logic [7:0] ERRCNT_OFF = 8'h02;

  // CTRL layout: bit0 EN, bits[3:1] WAIT
  localparam int CTRL_W        = 4;
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_WAIT_LSB = 1;
  localparam int CTRL_WAIT_MSB = 3;

  // Increment an 8-bit counter, sticking at all-ones
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : v + 8'h01;
  endfunction

endpackage

// File: rtl/dma_responder_mem.sv
// Word RAM for dma_responder: 2^AW x 16, per-byte write enables,
// asynchronous read. Contents are intentionally not reset.
module dma_responder_mem #(
  parameter int AW = 6
) (
  input  logic          i_clk,
  input  logic [1:0]    i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [15:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [15:0]   o_rdata
);

  logic [15:0] r_mem [0:(2**AW)-1];

  // Commit the selected byte lanes of the write word
  always_ff @(posedge i_clk) begin
    if (i_we[0]) begin
      r_mem[i_waddr][7:0] <= i_wdata[7:0];
    end
    if (i_we[1]) begin
      r_mem[i_waddr][15:8] <= i_wdata[15:8];
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dma_responder.sv
// dma_responder: DMA slave with a configurable wait-state memory window and
// a peripheral-bus config block (CTRL, ERRCNT).
// Optional feature macro: DMA_RESPONDER_TRACE_EN enables the 16-bit
// dma_ready history on the trace output; when undefined trace is 0.
module dma_responder #(
  parameter logic [14:0] BASE_ADDR = 15'h0260,
  parameter int          DEC_WD    = 2,
  parameter int          MEM_AW    = 6,
  parameter logic [15:0] WIN_BASE  = 16'hE000
) (
  input  logic        mclk,
  input  logic        puc_rst,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  output logic [15:0] per_dout,
  input  logic [14:0] dma_addr,
  input  logic [15:0] dma_din,
  input  logic        dma_en,
  input  logic [1:0]  dma_we,
  output logic [15:0] dma_dout,
  output logic        dma_ready,
  output logic        dma_resp,
  output logic [15:0] trace
);

  import dma_responder_pkg::*;

  // ---------------- config registers ----------------
  logic [CTRL_W-1:0] r_ctrl;
  logic [7:0]        r_errcnt;

  logic       w_sel;
  logic [7:0] w_reg_off;
  logic       w_ctrl_wr;
  logic       w_err_wr;
  logic       w_err_inc;
  logic [15:0] w_per_dout;

  assign w_sel     = per_en && (per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
  assign w_reg_off = 8'({per_addr[DEC_WD-2:0], 1'b0});
  assign w_ctrl_wr = w_sel && (w_reg_off == CTRL_OFF) && per_we[0];
  assign w_err_wr  = w_sel && (w_reg_off == ERRCNT_OFF) && (per_we != 2'b00);

  // CTRL holds its value unless written; ERRCNT clear beats an error increment
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      r_ctrl   <= '0;
      r_errcnt <= 8'h00;
    end else begin
      if (w_ctrl_wr) begin
        r_ctrl <= per_din[CTRL_W-1:0];
      end
      if (w_err_wr) begin
        r_errcnt <= 8'h00;
      end else if (w_err_inc) begin
        r_errcnt <= sat_inc8(r_errcnt);
      end
    end
  end

  // Combinational register read, zero when unselected, on writes or in reset
  always_comb begin
    w_per_dout = 16'h0000;
    if (w_sel && (per_we == 2'b00) && !puc_rst) begin
      case (w_reg_off)
        CTRL_OFF:   w_per_dout = {{(16-CTRL_W){1'b0}}, r_ctrl};
        ERRCNT_OFF: w_per_dout = {8'h00, r_errcnt};
        default:    w_per_dout = 16'h0000;
      endcase
    end else begin
      w_per_dout = 16'h0000;
    end
  end

  assign per_dout = w_per_dout;

  // ---------------- DMA request FSM ----------------
  state_e            r_state;
  logic [2:0]        r_cnt;
  logic [MEM_AW-1:0] r_idx;
  logic [15:0]       r_din;
  logic [1:0]        r_we;
  logic              r_legal;
  logic              r_ready;
  logic              r_resp;
  logic [15:0]       r_dout;

  logic              w_legal_now;
  logic [2:0]        w_ctrl_wait;
  logic [MEM_AW-1:0] w_mem_raddr;
  logic [15:0]       w_mem_rdata;
  logic [1:0]        w_mem_we;
  logic              w_done_legal;
  logic [1:0]        w_done_we;
  logic [15:0]       w_done_dout;

  assign w_legal_now = r_ctrl[CTRL_EN_BIT] &&
                       (dma_addr[14:MEM_AW] == WIN_BASE[15:MEM_AW+1]);
  assign w_ctrl_wait = r_ctrl[CTRL_WAIT_MSB:CTRL_WAIT_LSB];

  // In IDLE the zero-wait path needs the live request; otherwise the latched one
  assign w_mem_raddr  = (r_state == ST_IDLE) ? dma_addr[MEM_AW-1:0] : r_idx;
  assign w_done_legal = (r_state == ST_IDLE) ? w_legal_now : r_legal;
  assign w_done_we    = (r_state == ST_IDLE) ? dma_we : r_we;
  assign w_done_dout  = (w_done_legal && (w_done_we == 2'b00)) ? w_mem_rdata : 16'h0000;

  // Writes commit at the edge that closes DONE; reset suppresses them
  assign w_mem_we  = ((r_state == ST_DONE) && r_legal && !puc_rst) ? r_we : 2'b00;
  assign w_err_inc = (r_state == ST_DONE) && !r_legal;

  // Request sequencing with registered ready/resp/dout
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 3'd0;
      r_idx   <= '0;
      r_din   <= 16'h0000;
      r_we    <= 2'b00;
      r_legal <= 1'b0;
      r_ready <= 1'b0;
      r_resp  <= 1'b0;
      r_dout  <= 16'h0000;
    end else begin
      r_ready <= 1'b0;
      r_resp  <= 1'b0;
      r_dout  <= 16'h0000;
      case (r_state)
        ST_IDLE: begin
          if (dma_en) begin
            r_idx   <= dma_addr[MEM_AW-1:0];
            r_din   <= dma_din;
            r_we    <= dma_we;
            r_legal <= w_legal_now;
            r_cnt   <= w_ctrl_wait;
            if (w_ctrl_wait == 3'd0) begin
              r_state <= ST_DONE;
              r_ready <= 1'b1;
              r_resp  <= !w_done_legal;
              r_dout  <= w_done_dout;
            end else begin
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!dma_en) begin
            r_state <= ST_IDLE;
          end else if (r_cnt == 3'd1) begin
            r_state <= ST_DONE;
            r_ready <= 1'b1;
            r_resp  <= !w_done_legal;
            r_dout  <= w_done_dout;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign dma_ready = r_ready;
  assign dma_resp  = r_resp;
  assign dma_dout  = r_dout;

  dma_responder_mem #(
    .AW(MEM_AW)
  ) u_mem (
    .i_clk  (mclk),
    .i_we   (w_mem_we),
    .i_waddr(r_idx),
    .i_wdata(r_din),
    .i_raddr(w_mem_raddr),
    .o_rdata(w_mem_rdata)
  );

`ifdef DMA_RESPONDER_TRACE_EN
  logic [15:0] r_trace;

  // Shift the registered ready flag into the history every cycle
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      r_trace <= 16'h0000;
    end else begin
      r_trace <= {r_trace[14:0], r_ready};
    end
  end

  assign trace = r_trace;
`else
  assign trace = 16'h0000;
`endif

  logic w_unused;
  assign w_unused = &{1'b0, per_din[15:CTRL_W]};

endmodule

// File: tb/tb_dma_responder.sv
// Scoreboard bench for dma_responder: stimulus pushes expected DMA responses,
// an independent monitor pops and compares whenever dma_ready is seen.
module tb_dma_responder;

  logic        mclk = 1'b0;
  logic        puc_rst;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic        per_en;
  logic [1:0]  per_we;
  logic [15:0] per_dout;
  logic [14:0] dma_addr;
  logic [15:0] dma_din;
  logic        dma_en;
  logic [1:0]  dma_we;
  logic [15:0] dma_dout;
  logic        dma_ready;
  logic        dma_resp;
  logic [15:0] trace;

  always #5 mclk = ~mclk;

  dma_responder dut (
    .mclk(mclk), .puc_rst(puc_rst),
    .per_addr(per_addr), .per_din(per_din), .per_en(per_en), .per_we(per_we),
    .per_dout(per_dout),
    .dma_addr(dma_addr), .dma_din(dma_din), .dma_en(dma_en), .dma_we(dma_we),
    .dma_dout(dma_dout), .dma_ready(dma_ready), .dma_resp(dma_resp),
    .trace(trace)
  );

  localparam logic [13:0] A_CTRL = 14'h0130;
  localparam logic [13:0] A_ERR  = 14'h0131;

  int n_tests = 0;
  int n_fail  = 0;
  logic [16:0] sb_q[$];

  // Reference model state
  logic [15:0] m_mem [64];
  bit          m_en;
  int          m_wait;
  int          m_err;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [15:0] model_reg(logic [13:0] a);
    if (a == A_CTRL) return {12'h000, 3'(m_wait), m_en};
    if (a == A_ERR)  return 16'(m_err);
    return 16'h0000;
  endfunction

  // Monitor: every DONE must match the oldest outstanding expectation
  always @(negedge mclk) begin
    logic [16:0] e;
    if (!puc_rst) begin
      if (dma_ready) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_ready: got ready=1 expected no response");
        end else begin
          e = sb_q.pop_front();
          check("dma_resp", 32'(dma_resp), 32'(e[16]));
          check("dma_dout", 32'(dma_dout), 32'(e[15:0]));
        end
      end else begin
        check("quiet_outputs", 32'({dma_resp, dma_dout}), 32'h0);
      end
    end
  end

  task automatic reg_write(input logic [13:0] a, input logic [15:0] d, input logic [1:0] we);
    @(posedge mclk); #1;
    per_en = 1'b1; per_addr = a; per_din = d; per_we = we;
    #1;
    check("per_dout_during_write", 32'(per_dout), 32'h0);
    @(posedge mclk); #1;
    per_en = 1'b0; per_we = 2'b00;
    if (a == A_CTRL && we[0]) begin
      m_en = d[0];
      m_wait = int'(d[3:1]);
    end
    if (a == A_ERR && we != 2'b00) m_err = 0;
  endtask

  task automatic reg_read(input logic [13:0] a, input string name);
    @(posedge mclk); #1;
    per_en = 1'b1; per_addr = a; per_we = 2'b00;
    #1;
    check(name, 32'(per_dout), 32'(model_reg(a)));
    per_en = 1'b0;
  endtask

  task automatic dma_xfer(input logic [15:0] a, input logic [15:0] d, input logic [1:0] we);
    bit legal;
    int idx;
    int n;
    bit got;
    logic [15:0] exp_d;
    legal = m_en && (a >= 16'hE000) && (a < 16'hE080);
    idx   = int'((a - 16'hE000) >> 1) & 63;
    exp_d = (legal && we == 2'b00) ? m_mem[idx] : 16'h0000;
    sb_q.push_back({!legal, exp_d});
    @(posedge mclk); #1;
    dma_addr = a[15:1]; dma_din = d; dma_we = we; dma_en = 1'b1;
    @(posedge mclk);
    got = 1'b0;
    for (n = 0; n <= 20; n++) begin
      #1;
      if (dma_ready) begin
        got = 1'b1;
        break;
      end
      @(posedge mclk);
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL dma_timeout: got no ready within 20 cycles expected ready after %0d", m_wait);
      void'(sb_q.pop_back());
    end else begin
      check("ready_latency", 32'(n), 32'(m_wait));
    end
    dma_en = 1'b0;
    if (legal && we[0]) m_mem[idx][7:0]  = d[7:0];
    if (legal && we[1]) m_mem[idx][15:8] = d[15:8];
    if (!legal && m_err < 255) m_err++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    puc_rst = 1'b1; per_addr = '0; per_din = '0; per_en = 1'b0; per_we = 2'b00;
    dma_addr = '0; dma_din = '0; dma_en = 1'b0; dma_we = 2'b00;
    m_en = 1'b0; m_wait = 0; m_err = 0;
    repeat (3) @(posedge mclk);
    #1;
    check("rst_ready", 32'(dma_ready), 32'h0);
    check("rst_resp", 32'(dma_resp), 32'h0);
    check("rst_dout", 32'(dma_dout), 32'h0);
    check("rst_trace", 32'(trace), 32'h0);
    puc_rst = 1'b0;
    reg_read(A_CTRL, "rst_ctrl");
    reg_read(A_ERR, "rst_errcnt");
    reg_read(14'h0140, "unselected_read");

    // Fill the whole window so every word has a known value
    reg_write(A_CTRL, 16'h0001, 2'b11);
    for (int i = 0; i < 64; i++) dma_xfer(16'hE000 + 16'(2 * i), 16'($urandom), 2'b11);

    // Zero-wait write then readback
    dma_xfer(16'hE004, 16'hA55A, 2'b11);
    dma_xfer(16'hE004, 16'h0000, 2'b00);
    // WAIT=3 read
    reg_write(A_CTRL, 16'h0007, 2'b11);
    reg_read(A_CTRL, "ctrl_wait3");
    dma_xfer(16'hE004, 16'h0000, 2'b00);
    // Low-lane-only write
    dma_xfer(16'hE004, 16'h1234, 2'b01);
    dma_xfer(16'hE004, 16'h0000, 2'b00);

    // Errors: outside window, then EN=0
    dma_xfer(16'hD000, 16'hBEEF, 2'b11);
    reg_write(A_CTRL, 16'h0000, 2'b11);
    dma_xfer(16'hE004, 16'hFFFF, 2'b11);
    dma_xfer(16'hE006, 16'h0000, 2'b00);
    reg_write(A_CTRL, 16'h0001, 2'b11);
    dma_xfer(16'hE004, 16'h0000, 2'b00);
    reg_read(A_ERR, "errcnt_after_errors");

    // Abort: WAIT=5, drop dma_en two cycles after acceptance
    reg_write(A_CTRL, 16'h000B, 2'b11);
    @(posedge mclk); #1;
    dma_addr = 15'(16'hE008 >> 1); dma_din = 16'hFFFF; dma_we = 2'b11; dma_en = 1'b1;
    @(posedge mclk);
    repeat (2) @(posedge mclk);
    #1 dma_en = 1'b0;
    repeat (10) @(posedge mclk);
    reg_write(A_CTRL, 16'h0001, 2'b11);
    dma_xfer(16'hE008, 16'h0000, 2'b00);
    reg_read(A_ERR, "errcnt_after_abort");

    // Clear of ERRCNT in the same cycle as an increment wins
    dma_xfer(16'hD000, 16'h0000, 2'b11);
    per_en = 1'b1; per_addr = A_ERR; per_din = 16'h0000; per_we = 2'b11;
    @(posedge mclk); #1;
    per_en = 1'b0; per_we = 2'b00;
    m_err = 0;
    reg_read(A_ERR, "errcnt_clear_wins");

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      int r;
      logic [15:0] a;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        reg_write(A_CTRL, {12'h000, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0)}, 2'b11);
      end else if (r == 1) begin
        reg_read(($urandom_range(0, 1) == 0) ? A_CTRL : A_ERR, "rand_reg_read");
      end else begin
        if ($urandom_range(0, 3) != 0) a = 16'hE000 + 16'(2 * $urandom_range(0, 63));
        else a = 16'($urandom) & 16'hFFFE;
        dma_xfer(a, 16'($urandom), 2'($urandom_range(0, 3)));
      end
    end

    // Saturation of ERRCNT
    reg_write(A_CTRL, 16'h0001, 2'b11);
    for (int i = 0; i < 300; i++) dma_xfer(16'hD000 + 16'(2 * (i % 8)), 16'h0000, 2'b00);
    reg_read(A_ERR, "errcnt_saturated");
    reg_write(A_ERR, 16'h0000, 2'b01);
    reg_read(A_ERR, "errcnt_cleared");

    // Three back-to-back zero-wait transfers for the ready history
    dma_xfer(16'hE010, 16'h0000, 2'b00);
    dma_xfer(16'hE012, 16'h0000, 2'b00);
    dma_xfer(16'hE014, 16'h0000, 2'b00);
    @(posedge mclk);
    @(posedge mclk); #1;
`ifdef DMA_RESPONDER_TRACE_EN
    check("trace_history", 32'(trace[5:0]), 32'h2A);
`else
    check("trace_tied_off", 32'(trace), 32'h0);
`endif

    // Reset in the middle of a WAIT
    reg_write(A_CTRL, 16'h000B, 2'b11);
    dma_xfer(16'hD000, 16'h0000, 2'b00);
    @(posedge mclk); #1;
    dma_addr = 15'(16'hE00C >> 1); dma_din = 16'hFFFF; dma_we = 2'b11; dma_en = 1'b1;
    @(posedge mclk);
    @(posedge mclk); #1;
    puc_rst = 1'b1; dma_en = 1'b0;
    per_en = 1'b1; per_addr = A_CTRL; per_we = 2'b00;
    @(posedge mclk); #1;
    check("midwait_rst_ready", 32'(dma_ready), 32'h0);
    check("midwait_rst_resp", 32'(dma_resp), 32'h0);
    check("midwait_rst_dout", 32'(dma_dout), 32'h0);
    check("midwait_rst_per_dout", 32'(per_dout), 32'h0);
    check("midwait_rst_trace", 32'(trace), 32'h0);
    puc_rst = 1'b0; per_en = 1'b0;
    m_en = 1'b0; m_wait = 0; m_err = 0;
    reg_read(A_CTRL, "ctrl_after_rst");
    reg_read(A_ERR, "errcnt_after_rst");
    reg_write(A_CTRL, 16'h0001, 2'b11);
    dma_xfer(16'hE00C, 16'h0000, 2'b00);

    repeat (3) @(posedge mclk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
